// File: rtl/cache_axi_mem_bridge.sv
// Memory-side responder for the cache: turns each block request into one AXI4 INCR burst.
// Write-backs go out as AW/W/B, misses come back as AR/R and are returned over the load port.
module cache_axi_mem_bridge #(
   parameter int ADDR_SIZE  = 32,
   parameter int DATA_SIZE  = 32,
   parameter int BLOCK_SIZE = 6,
   parameter int BLOCKS     = (2**BLOCK_SIZE)/(DATA_SIZE/8)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          addr_valid_in,
   input  logic [ADDR_SIZE-1:0]          addr_in,
   input  logic                          rw_in,
   input  logic                          valid_wb,
   input  logic [BLOCKS*DATA_SIZE-1:0]   data_wb,
   output logic                          ready_wb,
   output logic                          valid_ld,
   output logic [BLOCKS*DATA_SIZE-1:0]   data_ld,
   input  logic                          ready_ld,
   output logic [ADDR_SIZE-1:0]          awaddr,
   output logic [7:0]                    awlen,
   output logic [2:0]                    awsize,
   output logic [1:0]                    awburst,
   output logic                          awvalid,
   input  logic                          awready,
   output logic [DATA_SIZE-1:0]          wdata,
   output logic [DATA_SIZE/8-1:0]        wstrb,
   output logic                          wlast,
   output logic                          wvalid,
   input  logic                          wready,
   input  logic [1:0]                    bresp,
   input  logic                          bvalid,
   output logic                          bready,
   output logic [ADDR_SIZE-1:0]          araddr,
   output logic [7:0]                    arlen,
   output logic [2:0]                    arsize,
   output logic [1:0]                    arburst,
   output logic                          arvalid,
   input  logic                          arready,
   input  logic [DATA_SIZE-1:0]          rdata,
   input  logic [1:0]                    rresp,
   input  logic                          rlast,
   input  logic                          rvalid,
   output logic                          rready,
   output logic                          bus_err
);

   localparam int BEAT_W = $clog2(BLOCKS);
   localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BLOCKS-1);
   localparam logic [ADDR_SIZE-1:0] OFS_MASK  = ADDR_SIZE'((2**BLOCK_SIZE)-1);

   typedef enum logic [2:0] {StIdle, StWbData, StAw, StW, StB, StAr, StR, StLd} state_t;

   state_t                              r_state;
   logic [BEAT_W-1:0]                   r_beat;
   logic [ADDR_SIZE-1:0]                r_addr;
   logic [BLOCKS-1:0][DATA_SIZE-1:0]    r_buf;
   logic                                r_bus_err;
   logic                                r_ready_wb;
   logic                                r_valid_ld;
   logic                                r_awvalid;
   logic                                r_wvalid;
   logic                                r_bready;
   logic                                r_arvalid;
   logic                                r_rready;
   logic                                w_last_beat;

   assign w_last_beat = (r_beat == LAST_BEAT);

   assign awaddr  = r_addr;
   assign araddr  = r_addr;
   assign awlen   = 8'(BLOCKS-1);
   assign arlen   = 8'(BLOCKS-1);
   assign awsize  = 3'($clog2(DATA_SIZE/8));
   assign arsize  = 3'($clog2(DATA_SIZE/8));
   assign awburst = 2'b01;
   assign arburst = 2'b01;
   assign wstrb   = '1;

   // W payload is a pure function of registered state, so it cannot move during a stall.
   assign wdata    = r_buf[r_beat];
   assign wlast    = r_wvalid && w_last_beat;
   assign wvalid   = r_wvalid;
   assign awvalid  = r_awvalid;
   assign bready   = r_bready;
   assign arvalid  = r_arvalid;
   assign rready   = r_rready;
   assign ready_wb = r_ready_wb;
   assign valid_ld = r_valid_ld;
   assign data_ld  = r_buf;
   assign bus_err  = r_bus_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_beat     <= '0;
         r_bus_err  <= 1'b0;
         r_ready_wb <= 1'b0;
         r_valid_ld <= 1'b0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (addr_valid_in) begin
                  r_addr <= addr_in & ~OFS_MASK;
                  if (rw_in) begin
                     r_ready_wb <= 1'b1;
                     r_state    <= StWbData;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= StAr;
                  end
               end
            end
            StWbData: begin
               if (valid_wb) begin
                  r_buf      <= data_wb;
                  r_ready_wb <= 1'b0;
                  r_awvalid  <= 1'b1;
                  r_state    <= StAw;
               end
            end
            StAw: begin
               if (awready) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b1;
                  r_state   <= StW;
               end
            end
            StW: begin
               if (wready) begin
                  if (w_last_beat) begin
                     r_beat   <= '0;
                     r_wvalid <= 1'b0;
                     r_bready <= 1'b1;
                     r_state  <= StB;
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
            end
            StB: begin
               if (bvalid) begin
                  if (bresp != 2'b00) r_bus_err <= 1'b1;
                  r_bready <= 1'b0;
                  r_state  <= StIdle;
               end
            end
            StAr: begin
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= StR;
               end
            end
            StR: begin
               if (rvalid) begin
                  r_buf[r_beat] <= rdata;
                  // rlast must coincide with the final beat; the burst length is ours, not the slave's
                  if ((rresp != 2'b00) || (rlast != w_last_beat)) r_bus_err <= 1'b1;
                  if (w_last_beat) begin
                     r_beat     <= '0;
                     r_rready   <= 1'b0;
                     r_valid_ld <= 1'b1;
                     r_state    <= StLd;
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
            end
            StLd: begin
               if (ready_ld) begin
                  r_valid_ld <= 1'b0;
                  r_state    <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_axi_mem_bridge.sv
// Directed bench for cache_axi_mem_bridge: the bench plays both the cache and the AXI slave.
module tb_cache_axi_mem_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         addr_valid_in;
   logic [31:0]  addr_in;
   logic         rw_in;
   logic         valid_wb;
   logic [511:0] data_wb;
   logic         ready_wb;
   logic         valid_ld;
   logic [511:0] data_ld;
   logic         ready_ld;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic         bus_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cache_axi_mem_bridge dut (
      .clk(clk), .rst(rst), .addr_valid_in(addr_valid_in), .addr_in(addr_in), .rw_in(rw_in),
      .valid_wb(valid_wb), .data_wb(data_wb), .ready_wb(ready_wb), .valid_ld(valid_ld),
      .data_ld(data_ld), .ready_ld(ready_ld), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
      .bready(bready), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk(tag, {ready_wb, valid_ld, awvalid, wvalid, wlast, bready, arvalid, rready}, 64'h0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] base, input int wb_dly,
                           input int aw_dly, input logic [3:0] wpat, input logic [1:0] resp,
                           input int rst_beat, input logic exp_err);
      int beat;
      int cyc;
      for (int i = 0; i < 16; i++) data_wb[i*32 +: 32] = base + 32'(i);
      addr_in = addr; rw_in = 1'b1; addr_valid_in = 1'b1; valid_wb = 1'b0;
      tick();
      addr_valid_in = 1'b0;
      for (int k = 0; k < wb_dly; k++) begin
         chk("wb_ready_wait", ready_wb, 1);
         tick();
      end
      chk("wb_ready", ready_wb, 1);
      valid_wb = 1'b1;
      tick();
      valid_wb = 1'b0;
      chk("wb_ready_drop", ready_wb, 0);
      chk("aw_addr", awaddr, addr & ~32'h3F);
      chk("aw_len", awlen, 15);
      chk("aw_size", awsize, 2);
      chk("aw_burst", awburst, 1);
      chk("ar_quiet", arvalid, 0);
      for (int k = 0; k < aw_dly; k++) begin
         chk("aw_hold", awvalid, 1);
         tick();
      end
      chk("aw_valid", awvalid, 1);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      chk("aw_drop", awvalid, 0);
      beat = 0;
      cyc = 0;
      while (beat < 16 && cyc < 200) begin
         chk("w_valid", wvalid, 1);
         chk("w_data", wdata, base + 32'(beat));
         chk("w_last", wlast, (beat == 15) ? 1 : 0);
         if (beat == rst_beat) break;
         wready = wpat[cyc % 4];
         tick();
         if (wready) beat++;
         cyc++;
      end
      wready = 1'b0;
      if (rst_beat >= 0) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         chk_quiet("rst_mid_w");
         chk("rst_mid_w_err", bus_err, 0);
         return;
      end
      chk("w_done", wvalid, 0);
      chk("b_ready", bready, 1);
      tick();
      chk("b_wait", bready, 1);
      bvalid = 1'b1; bresp = resp;
      tick();
      bvalid = 1'b0; bresp = 2'b00;
      chk("b_drop", bready, 0);
      chk("wr_bus_err", bus_err, exp_err);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] base, input int early,
                          input bit stall, input logic exp_err, input bit rst_in_ld);
      int beat;
      int cyc;
      addr_in = addr; rw_in = 1'b0; addr_valid_in = 1'b1;
      tick();
      addr_valid_in = 1'b0;
      chk("ar_valid", arvalid, 1);
      chk("ar_addr", araddr, addr & ~32'h3F);
      chk("ar_len", arlen, 15);
      chk("ar_size", arsize, 2);
      chk("ar_burst", arburst, 1);
      chk("aw_quiet", awvalid, 0);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("r_ready", rready, 1);
      chk("ar_drop", arvalid, 0);
      beat = 0;
      cyc = 0;
      while (beat < 16) begin
         rvalid = stall ? ((cyc % 3) != 1) : 1'b1;
         rdata  = base + 32'(beat);
         rlast  = (early >= 0) ? (beat == early) : (beat == 15);
         // A stray request mid-burst must not start a second AR.
         addr_valid_in = (beat == 5);
         tick();
         addr_valid_in = 1'b0;
         if (rvalid) beat++;
         cyc++;
         chk("r_no_ar", arvalid, 0);
      end
      rvalid = 1'b0; rlast = 1'b0;
      chk("ld_valid", valid_ld, 1);
      chk("ld_rready_drop", rready, 0);
      chk("ld_word3", data_ld[3*32 +: 32], base + 32'd3);
      chk("ld_word15", data_ld[15*32 +: 32], base + 32'd15);
      chk("rd_bus_err", bus_err, exp_err);
      if (rst_in_ld) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         chk_quiet("rst_in_ld");
         return;
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("ld_hold", valid_ld, 1);
         chk("ld_word9", data_ld[9*32 +: 32], base + 32'd9);
      end
      ready_ld = 1'b1;
      tick();
      ready_ld = 1'b0;
      chk("ld_drop", valid_ld, 0);
   endtask

   initial begin
      rst = 1'b1; addr_valid_in = 1'b0; addr_in = '0; rw_in = 1'b0; valid_wb = 1'b0;
      data_wb = '0; ready_ld = 1'b0; awready = 1'b0; wready = 1'b0; bresp = 2'b00;
      bvalid = 1'b0; arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_quiet("reset_outs");
      chk("reset_bus_err", bus_err, 0);
      chk("wstrb", wstrb, 4'hF);

      do_write(32'h0000_1234, 32'hA000_0000, 0, 0, 4'b1111, 2'b00, -1, 1'b0);
      do_load(32'h8000_007C, 32'h5000_0000, -1, 1'b0, 1'b0, 1'b0);

      // ready_ld while idle must not disturb anything.
      ready_ld = 1'b1;
      tick();
      tick();
      ready_ld = 1'b0;
      chk_quiet("idle_ready_ld");

      do_write(32'h0000_4010, 32'hB000_0000, 4, 7, 4'b1001, 2'b10, -1, 1'b1);
      do_load(32'h0000_0100, 32'h6000_0000, -1, 1'b1, 1'b1, 1'b0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("err_cleared", bus_err, 0);

      do_load(32'h0000_0200, 32'h7000_0000, 9, 1'b0, 1'b1, 1'b0);
      do_write(32'h0000_0300, 32'hC000_0000, 0, 0, 4'b1111, 2'b00, 6, 1'b0);
      do_load(32'h0000_0400, 32'hD000_0000, -1, 1'b0, 1'b0, 1'b1);
      do_load(32'h0000_0500, 32'hE000_0000, -1, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
